// File: rtl/clk_cfg_pkg.sv
// Shared types and default timing for the clock-configuration sequencer.
package clk_cfg_pkg;

    localparam int unsigned SETTLE_CYCLES_DEF = 4;
    localparam int unsigned LOCK_CYCLES_DEF   = 16;

    typedef enum logic [1:0] {
        SRC_REF     = 2'd0,
        SRC_ROSC    = 2'd1,
        SRC_PLL     = 2'd2,
        SRC_ILLEGAL = 2'd3
    } src_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PARK,
        ST_PLL_UP,
        ST_SEL_SRC,
        ST_UNPARK,
        ST_SET_DIV,
        ST_PLL_DN,
        ST_FIN
    } state_e;

endpackage

// File: rtl/clk_cfg_tmr.sv
// Loadable down-counter shared by every wait state of the sequencer.
module clk_cfg_tmr
    import clk_cfg_pkg::*;
#(
    parameter int unsigned W = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/clk_cfg_seq.sv
// Sequences rst_clk_ctrl controls: park on reference, PLL up, select, unpark, divide, PLL down.
module clk_cfg_seq
    import clk_cfg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int unsigned LOCK_CYCLES   = LOCK_CYCLES_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [1:0] req_src_i,
    input  logic [1:0] req_rosc_i,
    input  logic [1:0] req_trim_i,
    input  logic [1:0] req_div_i,
    output logic       pll_en_o,
    output logic [1:0] pll_trim_o,
    output logic       sel_8mhz_o,
    output logic       sel_pll_o,
    output logic [1:0] sel_rosc_o,
    output logic [1:0] clk_div_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    localparam int unsigned MAX_WAIT = (SETTLE_CYCLES > LOCK_CYCLES) ? SETTLE_CYCLES : LOCK_CYCLES;
    localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);
    // A state holding N cycles loads N-1 and leaves on the edge after expiry.
    localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_LOCK   = CNT_W'(LOCK_CYCLES - 1);

    state_e           state_q, state_d;
    src_e             tgt_q;
    logic [1:0]       rosc_q, trim_q, div_q;
    logic             ill_q, ill_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_exp;
    logic             accept;

    logic       pll_en_q, pll_en_d, sel_8mhz_q, sel_8mhz_d, sel_pll_q, sel_pll_d;
    logic [1:0] pll_trim_q, pll_trim_d, sel_rosc_q, sel_rosc_d, clk_div_q, clk_div_d;
    logic       busy_q, ready_q, done_q, err_q;

    assign accept = req_valid_i && (state_q == ST_IDLE);

    clk_cfg_tmr #(.W(CNT_W)) u_tmr (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (tmr_load),
        .value_i   (tmr_val),
        .expired_o (tmr_exp)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = LD_SETTLE;
        ill_d    = accept && (src_e'(req_src_i) == SRC_ILLEGAL);
        unique case (state_q)
            ST_IDLE: begin
                if (accept && (src_e'(req_src_i) != SRC_ILLEGAL)) begin
                    state_d  = ST_PARK;
                    tmr_load = 1'b1;
                end
            end
            ST_PARK: begin
                if (tmr_exp) begin
                    tmr_load = 1'b1;
                    if (tgt_q == SRC_PLL) begin
                        state_d = ST_PLL_UP;
                        tmr_val = LD_LOCK;
                    end else if (tgt_q == SRC_ROSC) begin
                        state_d = ST_SEL_SRC;
                    end else begin
                        state_d = ST_PLL_DN;
                    end
                end
            end
            ST_PLL_UP:  if (tmr_exp) begin state_d = ST_SEL_SRC; tmr_load = 1'b1; end
            ST_SEL_SRC: if (tmr_exp) begin state_d = ST_UNPARK;  tmr_load = 1'b1; end
            ST_UNPARK:  if (tmr_exp) begin state_d = ST_SET_DIV; tmr_load = 1'b1; end
            ST_SET_DIV: begin
                if (tmr_exp) begin
                    tmr_load = (tgt_q != SRC_PLL);
                    state_d  = (tgt_q == SRC_PLL) ? ST_FIN : ST_PLL_DN;
                end
            end
            ST_PLL_DN:  if (tmr_exp) state_d = ST_FIN;
            ST_FIN:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Controls follow the state one cycle later, so every output is a plain flop.
    always_comb begin
        pll_en_d   = pll_en_q;
        pll_trim_d = pll_trim_q;
        sel_8mhz_d = sel_8mhz_q;
        sel_pll_d  = sel_pll_q;
        sel_rosc_d = sel_rosc_q;
        clk_div_d  = clk_div_q;
        unique case (state_q)
            ST_PARK:    begin sel_8mhz_d = 1'b1; clk_div_d = 2'd0; end
            ST_PLL_UP:  begin pll_trim_d = trim_q; pll_en_d = 1'b1; end
            ST_SEL_SRC: begin sel_pll_d = (tgt_q == SRC_PLL); sel_rosc_d = rosc_q; end
            ST_UNPARK:  sel_8mhz_d = 1'b0;
            ST_SET_DIV: clk_div_d = div_q;
            ST_PLL_DN:  pll_en_d = 1'b0;
            default:    ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tgt_q      <= SRC_REF;
            rosc_q     <= 2'd0;
            trim_q     <= 2'd0;
            div_q      <= 2'd0;
            ill_q      <= 1'b0;
            pll_en_q   <= 1'b0;
            pll_trim_q <= 2'd0;
            sel_8mhz_q <= 1'b1;
            sel_pll_q  <= 1'b0;
            sel_rosc_q <= 2'd0;
            clk_div_q  <= 2'd0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                tgt_q  <= src_e'(req_src_i);
                rosc_q <= req_rosc_i;
                trim_q <= req_trim_i;
                div_q  <= req_div_i;
            end
            ill_q      <= ill_d;
            pll_en_q   <= pll_en_d;
            pll_trim_q <= pll_trim_d;
            sel_8mhz_q <= sel_8mhz_d;
            sel_pll_q  <= sel_pll_d;
            sel_rosc_q <= sel_rosc_d;
            clk_div_q  <= clk_div_d;
            busy_q     <= (state_d != ST_IDLE);
            ready_q    <= (state_d == ST_IDLE);
            done_q     <= (state_q == ST_FIN);
            err_q      <= ill_q;
        end
    end

    assign req_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign pll_en_o    = pll_en_q;
    assign pll_trim_o  = pll_trim_q;
    assign sel_8mhz_o  = sel_8mhz_q;
    assign sel_pll_o   = sel_pll_q;
    assign sel_rosc_o  = sel_rosc_q;
    assign clk_div_o   = clk_div_q;

endmodule

// File: doc/clk_cfg_seq.md
# clk_cfg_seq

Clock-configuration sequencer that drives the control inputs of `rst_clk_ctrl` (`pll_en`, `pll_trim`, `sel_8mhz`, `sel_pll`, `sel_rosc`, `clk_div`) from a single request handshake. It replaces ad-hoc software pokes with a fixed, glitch-safe order:

- park the system clock on the reference;
- bring the PLL up and wait for lock;
- select the source;
- unpark;
- apply the divider;
- shut the PLL down if unused.

It runs on the system clock produced by `rst_clk_ctrl` and sits between the SoC register file and that controller.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: cycles held after each mux/divider step. Must be ≥1.
- `LOCK_CYCLES`, default 16: cycles held after asserting `pll_en`. Must be ≥1.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: system clock from `rst_clk_ctrl`.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: configuration request valid.
- `req_ready` output 1: high only in IDLE.
- `req_src` input 2: 0 = REF, 1 = ROSC, 2 = PLL, 3 = illegal.
- `req_rosc` input 2: ring-oscillator frequency select.
- `req_trim` input 2: PLL trim.
- `req_div` input 2: divide system clock by 2^`req_div`.
- `pll_en`, `sel_8mhz`, `sel_pll` output 1 each: to `rst_clk_ctrl`.
- `pll_trim`, `sel_rosc`, `clk_div` output 2 each: to `rst_clk_ctrl`.
- `busy` output 1: high while not in IDLE.
- `done` output 1: one-cycle pulse when a sequence completes.
- `err` output 1: one-cycle pulse when an illegal request is accepted.

## Operation
- **Reset values:**
  - `pll_en`=0, `pll_trim`=0, `sel_8mhz`=1, `sel_pll`=0, `sel_rosc`=0, `clk_div`=0.
  - `busy`=0, `done`=0, `err`=0, `req_ready`=1. State is IDLE.
- **Accept:** a request is accepted on a `clk` edge with `req_valid && req_ready`. The request fields are latched at that edge. `req_valid` while `busy` is ignored; there is no queuing.
- **Illegal source:** `req_src`=3 is accepted. `err` pulses on the next cycle and the FSM stays in IDLE. No control output changes.
- **States, in order.** Each executed state registers its output change on entry, then holds for its wait count before advancing.
  - **PARK** (wait `SETTLE_CYCLES`): `sel_8mhz`=1, `clk_div`=0. Always executed.
  - **PLL_UP** (wait `LOCK_CYCLES`): `pll_trim`=trim, `pll_en`=1. Executed only when the target is PLL.
  - **SEL_SRC** (wait `SETTLE_CYCLES`): `sel_pll`=(target==PLL), `sel_rosc`=rosc. Skipped when the target is REF.
  - **UNPARK** (wait `SETTLE_CYCLES`): `sel_8mhz`=0. Skipped when the target is REF.
  - **SET_DIV** (wait `SETTLE_CYCLES`): `clk_div`=div. Skipped when the target is REF, which always runs at div 0.
  - **PLL_DN** (wait `SETTLE_CYCLES`): `pll_en`=0. Executed only when the target is not PLL.
  - **FIN**: `done`=1 for one cycle, then return to IDLE (`req_ready`=1 in the same cycle).
- **Sequence ordering rule:** `sel_pll` and `sel_rosc` never change while `sel_8mhz`=0, and `clk_div` never changes while `sel_8mhz`=0 except in SET_DIV.
- **Re-requesting the current configuration:** the full sequence still runs, including PARK. There is no shortcut.
- **Mid-operation reset:** asynchronous `rst_n` low forces every output to its reset value immediately. The FSM returns to IDLE and the latched request is discarded.

## Timing
- Accept at edge 0. Each executed state occupies exactly its wait count of cycles. `done` is asserted in the cycle after the last executed state.
- `done` cycle by target:
  - PLL: 1+4·S+L. With defaults this is cycle 33.
  - ROSC: 1+5·S. With defaults this is cycle 21.
  - REF: 1+2·S. With defaults this is cycle 9.
- Each output change is visible one cycle after entry to its state. Outputs are driven from registers only, with no combinational path from the `req_*` inputs.
- The counter is reloaded on every state entry. Its width is $clog2(max(S,L)+1).
- Cycle counts refer to the generated system clock, so wall-clock duration scales with the current `clk_div` and source.

## Structure
- Package `clk_cfg_pkg` holds:
  - `src_e` (REF, ROSC, PLL, ILLEGAL);
  - `state_e` (IDLE, PARK, PLL_UP, SEL_SRC, UNPARK, SET_DIV, PLL_DN, FIN);
  - the default `SETTLE_CYCLES` and `LOCK_CYCLES` constants.
- Sub-module `clk_cfg_tmr`: a loadable down-counter with a `load`/`value` input and an `expired` flag. It is shared by all wait states.

## Test plan
- **Reset:** assert `rst_n` low asynchronously mid-cycle → all outputs at reset values before the next edge, with `req_ready`=1.
- **PLL request:** from reset, request src=PLL, trim=2, div=1 → `pll_en`=1 at cycle 5, `sel_pll`=1 at cycle 21, `sel_8mhz`=0 at cycle 25, `clk_div`=1 at cycle 29, `done` at cycle 33.
- **PLL to ROSC:** from PLL/div1, request src=ROSC, rosc=3, div=3 → `sel_8mhz`=1 and `clk_div`=0 at cycle 1, `sel_rosc`=3 and `sel_pll`=0 at cycle 5, `clk_div`=3 at cycle 13, `pll_en`=0 at cycle 17, `done` at cycle 21.
- **REF request:** request src=REF → `sel_8mhz` held at 1, `clk_div` held at 0, `done` at cycle 9.
- **Illegal request:** src=3 → `err` pulse at cycle 1 and no output changes. A second `req_valid` while `busy` is ignored, with `req_ready`=0 throughout.
- **Reset mid-sequence:** `rst_n` low during PLL_UP → `pll_en` drops immediately. After release the FSM is in IDLE and a new request completes normally.
